// File: rtl/regscan_pkg.sv
// Shared types and constants for the register-file scan reader.
package regscan_pkg;

    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_DATA_W   = 32;

    localparam logic [4:0] CHECKSUM_INDEX = 5'h1F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        SEND_LO  = 3'd2,
        SEND_HI  = 3'd3,
        SEND_SUM = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/regfile_scan_reader.sv
// Walks the register file two entries at a time and streams each word over valid/ready.
// Optional REGSCAN_CHECKSUM_EN appends an XOR checksum word after the last register.
module regfile_scan_reader
    import regscan_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] a1_o,
    output logic [ADDR_W-1:0] a2_o,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_index_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] buf_lo_q, buf_lo_d, buf_hi_q, buf_hi_d;
    logic [DATA_W-1:0] acc_d;

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              done_q, done_d;

    logic handshake_c;
    logic last_pair_c;
    logic scan_start_c;

    assign handshake_c  = out_valid_q & out_ready_i;
    assign last_pair_c  = (idx_q + ADDR_W'(2)) == ADDR_W'(NUM_REGS);
    assign scan_start_c = (state_q == IDLE) & start_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)     state_d = READ;
            READ:                     state_d = SEND_LO;
            SEND_LO: if (handshake_c) state_d = SEND_HI;
`ifdef REGSCAN_CHECKSUM_EN
            SEND_HI: if (handshake_c) state_d = last_pair_c ? SEND_SUM : READ;
            SEND_SUM: if (handshake_c) state_d = DONE;
`else
            SEND_HI: if (handshake_c) state_d = last_pair_c ? DONE : READ;
`endif
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Datapath next-state: pair index, snapshot buffers, checksum.
    always_comb begin
        idx_d    = idx_q;
        buf_lo_d = buf_lo_q;
        buf_hi_d = buf_hi_q;
        if (scan_start_c) begin
            idx_d = '0;
        end else if ((state_q == SEND_HI) && handshake_c && !last_pair_c) begin
            idx_d = idx_q + ADDR_W'(2);
        end
        if (state_q == READ) begin
            buf_lo_d = rd1_i;
            buf_hi_d = rd2_i;
        end
    end

`ifdef REGSCAN_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;

    always_comb begin
        acc_d = acc_q;
        if (scan_start_c) begin
            acc_d = '0;
        end else if (handshake_c && ((state_q == SEND_LO) || (state_q == SEND_HI))) begin
            acc_d = acc_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) acc_q <= '0;
        else         acc_q <= acc_d;
    end
`else
    assign acc_d = '0;
`endif

    // Registered outputs are decoded from the upcoming state so they line up with it.
    always_comb begin
        busy_d      = (state_d != IDLE);
        a1_d        = '0;
        a2_d        = '0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_index_d = '0;
        done_d      = 1'b0;
        case (state_d)
            READ: begin
                a1_d = idx_d;
                a2_d = idx_d + ADDR_W'(1);
            end
            SEND_LO: begin
                out_valid_d = 1'b1;
                out_data_d  = buf_lo_d;
                out_index_d = idx_d;
            end
            SEND_HI: begin
                out_valid_d = 1'b1;
                out_data_d  = buf_hi_d;
                out_index_d = idx_d + ADDR_W'(1);
            end
            SEND_SUM: begin
                out_valid_d = 1'b1;
                out_data_d  = acc_d;
                out_index_d = ADDR_W'(CHECKSUM_INDEX);
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q       <= '0;
            buf_lo_q    <= '0;
            buf_hi_q    <= '0;
            busy_q      <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            buf_lo_q    <= buf_lo_d;
            buf_hi_q    <= buf_hi_d;
            busy_q      <= busy_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign a1_o        = a1_q;
    assign a2_o        = a2_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_index_o = out_index_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: register-file model, random backpressure, snapshot model.
module tb_regfile_scan_reader;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
`ifdef REGSCAN_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic [AW-1:0] a1_o, a2_o;
    logic [DW-1:0] rd1_i, rd2_i;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] out_data_o;
    logic [AW-1:0] out_index_o;
    logic          done_o;

    logic [DW-1:0] regs [32];
    exp_t          exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            cyc_start = 0;
    int            ready_mode = 0;

    regfile_scan_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
        .a1_o(a1_o), .a2_o(a2_o), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_index_o(out_index_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd1_i = regs[a1_o];
    assign rd2_i = regs[a2_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer backpressure: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    always @(posedge clk) begin
        logic [3:0] pat;
        int         pc;
        pat = 4'b1001;
        #1;
        case (ready_mode)
            1: begin out_ready_i = pat[pc]; pc = (pc + 1) % 4; end
            2: out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every accepted word, checks stall stability and read addresses.
    always @(negedge clk) begin
        exp_t          e;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_index;
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid_o), 32'd1);
                check("stall_data", out_data_o, prev_data);
                check("stall_index", 32'(out_index_o), 32'(prev_index));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got index %0h data %0h, expected none", out_index_o, out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_data_o, e.data);
                    check("word_index", 32'(out_index_o), 32'(e.idx));
                end
            end
            if (busy_o && !out_valid_o && !done_o && exp_q.size() > 0) begin
                check("read_a1", 32'(a1_o), 32'(exp_q[0].idx));
                check("read_a2", 32'(a2_o), 32'(exp_q[0].idx) + 32'd1);
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_index = out_index_o;
        end
    end

    // Expected scan is the register contents at the moment the scan is requested.
    task automatic push_scan();
        exp_t          e;
        logic [DW-1:0] sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            e.data = regs[i];
            e.idx  = AW'(i);
            sum    = sum ^ regs[i];
            exp_q.push_back(e);
        end
        if (EXTRA != 0) begin
            e.data = sum;
            e.idx  = 5'h1F;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_scan(input bit hold);
        check("idle_before_start", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        push_scan();
        @(negedge clk);
        cyc_start = cyc;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done(input bit timed);
        int n = 0;
        while (done_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        if (n >= 2000) begin
            check("done_timeout", 32'(done_o), 32'd1);
        end else begin
            if (timed) check("done_cycle", 32'(cyc - cyc_start), 32'(3 * N / 2 + EXTRA));
            check("busy_in_done", 32'(busy_o), 32'd1);
            check("words_left", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            check("done_pulse_width", 32'(done_o), 32'd0);
            check("busy_after_done", 32'(busy_o), 32'd0);
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", out_data_o, 32'd0);
        check("rst_index", 32'(out_index_o), 32'd0);
        check("rst_a1", 32'(a1_o), 32'd0);
        check("rst_a2", 32'(a2_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
    endtask

    initial begin
        int  n;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset, with START also high to show reset wins.
        reset_i = 1'b1;
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        start_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Basic scan, always ready.
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        start_scan(1'b0);
        wait_done(1'b1);

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        start_scan(1'b0);
        wait_done(1'b0);
        ready_mode = 0;
        @(negedge clk);

        // START held across a whole scan, then a fresh scan.
        start_scan(1'b1);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        check("held_start_single_scan", 32'(busy_o), 32'd0);
        start_scan(1'b0);
        wait_done(1'b1);

        // Reset while index 3 is presented.
        start_scan(1'b0);
        n = 0;
        while (!(out_valid_o && out_index_o == AW'(3)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("saw_index3", 32'(out_index_o), 32'd3);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_valid", 32'(out_valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_o || busy_o) n++;
        end
        check("midrst_quiet", 32'(n), 32'd0);
        start_scan(1'b0);
        wait_done(1'b1);

        // Write reg2 right after pair 2/3 is captured: old value this scan, new value next scan.
        start_scan(1'b0);
        n = 0;
        while (!(busy_o && !out_valid_o && !done_o && a1_o == AW'(2)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("saw_read_pair2", 32'(a1_o), 32'd2);
        @(negedge clk);
        regs[2] = 32'hDEAD_BEEF;
        wait_done(1'b1);
        start_scan(1'b0);
        wait_done(1'b1);

        // One-hot registers: checksum word would be 0xFF.
        for (int i = 0; i < int'(N); i++) regs[i] = 32'd1 << i;
        start_scan(1'b0);
        wait_done(1'b1);

        // Random contents with random backpressure.
        ready_mode = 2;
        repeat (4) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            start_scan(1'b0);
            wait_done(1'b0);
            @(negedge clk);
        end
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scan_reader.md
# regfile_scan_reader

Sequential read-side master for the 32-bit register file: on a start pulse it walks all registers two at a time through the file's two combinational read ports (A1/RD1, A2/RD2), captures each pair, and streams the words out one per handshake on a valid/ready interface. It is the hardware replacement for the simulation-only register dump and sits between the register file's read ports and any debug or trace consumer.

## Interface
- NUM_REGS, 8: registers scanned, indices 0..NUM_REGS-1; must be even, 2..32
- ADDR_W, 5: register address width
- DATA_W, 32: register data width
- CLK  input  1  clock; all state updates on posedge CLK
- RESET  input  1  synchronous, active-high reset
- START  input  1  begin a scan; sampled only in IDLE
- BUSY  output  1  high in every state except IDLE
- A1  output  ADDR_W  read address to register file port 1
- A2  output  ADDR_W  read address to register file port 2
- RD1  input  DATA_W  register file read data, port 1 (combinational from A1)
- RD2  input  DATA_W  register file read data, port 2 (combinational from A2)
- OUT_VALID  output  1  OUT_DATA/OUT_INDEX valid
- OUT_READY  input  1  consumer accepts the word this cycle
- OUT_DATA  output  DATA_W  register contents
- OUT_INDEX  output  ADDR_W  register index of OUT_DATA
- DONE  output  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, READ, SEND_LO, SEND_HI, DONE (plus SEND_SUM under the configuration macro).
- IDLE: A1=A2=0, outputs low; START=1 -> READ with idx=0.
- READ: A1=idx, A2=idx+1; at the edge RD1->buf_lo, RD2->buf_hi; -> SEND_LO.
- SEND_LO: OUT_VALID=1, OUT_DATA=buf_lo, OUT_INDEX=idx; on OUT_VALID&OUT_READY -> SEND_HI.
- SEND_HI: OUT_DATA=buf_hi, OUT_INDEX=idx+1; on handshake: if idx+2==NUM_REGS -> DONE, else idx+=2 -> READ.
- DONE: DONE=1 for exactly one cycle -> IDLE.
- Handshake: OUT_DATA/OUT_INDEX held stable while OUT_VALID=1 and OUT_READY=0; OUT_VALID never drops without a handshake except on RESET.
- START while BUSY is ignored; no queuing.
- Captured words are a snapshot at the READ cycle; writes to the file after that are not reflected until the next scan.
- idx arithmetic is ADDR_W bits; no wrap occurs since NUM_REGS<=32.

## Timing
- Reset values: state IDLE, idx 0, buf_lo/buf_hi 0, BUSY 0, OUT_VALID 0, OUT_DATA 0, OUT_INDEX 0, A1 0, A2 0, DONE 0.
- START sampled at edge 0: READ in cycle 1, first OUT_VALID in cycle 2.
- OUT_READY held high: 3 cycles per pair (READ bubble + 2 words); DONE in cycle 3*NUM_REGS/2+1 (cycle 13 for 8 regs), BUSY low in the following cycle.
- Each cycle of OUT_READY=0 in SEND_LO/SEND_HI adds exactly one cycle.
- RESET mid-scan: next cycle IDLE with all reset values; no DONE pulse, partial scan discarded.
- RESET and START in the same cycle: RESET wins.

## Configuration
- REGSCAN_CHECKSUM_EN defined: a DATA_W XOR accumulator (cleared on START and RESET) folds in every accepted word; after the last SEND_HI handshake the FSM enters SEND_SUM, presenting OUT_DATA=accumulator, OUT_INDEX=all ones (5'h1F), then DONE after its handshake. Adds one cycle per scan.
- Not defined: no accumulator, no SEND_SUM; SEND_HI of the last pair goes directly to DONE.

## Structure
- Package regscan_pkg: state enum (IDLE, READ, SEND_LO, SEND_HI, SEND_SUM, DONE), CHECKSUM_INDEX constant (5'h1F), default widths.
- Single flat module; no sub-module. The capture buffer and FSM are small enough to stay inline.

## Test plan
- Reset, then registers i = 32'hA000_0000+i, START pulse, OUT_READY=1 -> words A0000000..A0000007 with indices 0..7, DONE in cycle 13, BUSY low in cycle 14.
- OUT_READY toggled 1,0,0,1 repeatedly -> OUT_DATA/OUT_INDEX stable during stalls, same 8 words in order, no duplicates or drops.
- START held high across a whole scan -> exactly one scan; a second START after BUSY falls starts a new scan from index 0.
- RESET asserted while OUT_VALID=1 on index 3 -> next cycle OUT_VALID=0, BUSY=0, no DONE; a new START restarts at index 0.
- Register 2 written (reg2=32'hDEAD_BEEF) in the cycle after pair 2/3 is captured -> scan reports the old reg2; the next scan reports DEADBEEF.
- With REGSCAN_CHECKSUM_EN, registers 1,2,4,...,128 -> ninth word has index 5'h1F and data 32'h0000_00FF; DONE one cycle later than without the macro.
